// File: rtl/pll_rst_seq.sv
// -----------------------------------------------------------------------------
// pll_rst_seq
//
// Reset and lock supervisor for the PLL that makes the 25 MHz pixel clock.
// The PLL is held in reset for a fixed number of reference cycles. The block
// then waits for lock, requires lock to stay high for a programmable number of
// cycles, and only then releases the system reset. Losing lock while running,
// or failing to lock within the timeout, restarts the whole sequence.
// Everything runs on the 50 MHz board clock, which is also the PLL input.
//
// Optional feature (macro PLL_RST_SEQ_RETRY_LIMIT_EN):
//   After MAX_RETRY consecutive lock timeouts the block parks in a terminal
//   failure state: pll_reset_o stays high and pll_fail_o is raised. Only
//   reset_i leaves that state. Without the macro, timeouts retry forever and
//   pll_fail_o is constant 0.
//
// Ports:
//   clkin_i      in   1  50 MHz reference clock, rising edge only
//   reset_i      in   1  asynchronous active-high block reset
//   pll_lock_i   in   1  PLL lock indicator, asynchronous to clkin_i
//   pll_reset_o  out  1  active-high reset to the PLL
//   sys_rst_o    out  1  active-high system reset (clkin_i domain)
//   ready_o      out  1  PLL locked and system reset released
//   relock_cnt_o out  8  lock losses seen while running, saturates at 255
//   pll_fail_o   out  1  permanent failure flag (retry-limit build only)
// -----------------------------------------------------------------------------
module pll_rst_seq #(
   parameter int RST_HOLD_CYC     = 10,
   parameter int LOCK_TIMEOUT_CYC = 50000,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int MAX_RETRY        = 3
) (
   input  logic       clkin_i,
   input  logic       reset_i,
   input  logic       pll_lock_i,
   output logic       pll_reset_o,
   output logic       sys_rst_o,
   output logic       ready_o,
   output logic [7:0] relock_cnt_o,
   output logic       pll_fail_o
);

   // One shared counter serves every timed state, so it is sized for the
   // longest interval.
   localparam int CNT_MAX_A = (RST_HOLD_CYC > LOCK_TIMEOUT_CYC) ? RST_HOLD_CYC : LOCK_TIMEOUT_CYC;
   localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYC) ? CNT_MAX_A : LOCK_STABLE_CYC;
   localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);

   typedef enum logic [2:0] {
      S_RST,
      S_WAIT,
      S_STAB,
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
      S_FAIL,
`endif
      S_RUN
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       relock_q, relock_d;
   logic             sync1_q, lock_s_q;
   logic             pll_reset_q, sys_rst_q, ready_q;

`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
   localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);

   logic [3:0] retry_q, retry_d;
   logic       pll_fail_q;
`endif

   // Next-state logic. The counter free-runs inside a state and is cleared on
   // every transition, so each state times its own interval from zero.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      relock_d = relock_q;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
      retry_d  = retry_q;
`endif
      case (state_q)
         S_RST: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (lock_s_q) begin
               state_d = S_STAB;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               cnt_d = '0;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
               if (retry_q == RETRY_LAST) begin
                  state_d = S_FAIL;
               end else begin
                  state_d = S_RST;
                  retry_d = retry_q + 4'd1;
               end
`else
               state_d = S_RST;
`endif
            end
         end
         S_STAB: begin
            // Any sampled low throws away the stability count; the lock
            // timeout restarts from zero in S_WAIT.
            if (!lock_s_q) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            cnt_d = '0;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
            retry_d = '0;
`endif
            if (!lock_s_q) begin
               state_d = S_RST;
               if (relock_q != 8'hFF) begin
                  relock_d = relock_q + 8'd1;
               end
            end
         end
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
         S_FAIL: begin
            cnt_d = '0;
         end
`endif
         default: begin
            state_d = S_RST;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counters and outputs. Outputs are decoded from the next state so
   // they move on the same edge as the state register.
   always_ff @(posedge clkin_i or posedge reset_i) begin
      if (reset_i) begin
         sync1_q     <= 1'b0;
         lock_s_q    <= 1'b0;
         state_q     <= S_RST;
         cnt_q       <= '0;
         relock_q    <= '0;
         pll_reset_q <= 1'b1;
         sys_rst_q   <= 1'b1;
         ready_q     <= 1'b0;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
         retry_q     <= '0;
         pll_fail_q  <= 1'b0;
`endif
      end else begin
         // Two-flop synchronizer for the asynchronous lock input.
         sync1_q     <= pll_lock_i;
         lock_s_q    <= sync1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         relock_q    <= relock_d;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
         retry_q     <= retry_d;
         pll_reset_q <= (state_d == S_RST) || (state_d == S_FAIL);
         pll_fail_q  <= (state_d == S_FAIL);
`else
         pll_reset_q <= (state_d == S_RST);
`endif
         sys_rst_q   <= (state_d != S_RUN);
         ready_q     <= (state_d == S_RUN);
      end
   end

   assign pll_reset_o  = pll_reset_q;
   assign sys_rst_o    = sys_rst_q;
   assign ready_o      = ready_q;
   assign relock_cnt_o = relock_q;

`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
   assign pll_fail_o = pll_fail_q;
`else
   // No terminal state exists in this build, so failure can never be flagged
   // whatever MAX_RETRY is set to.
   localparam bit RETRY_LIMIT_EN = 1'b0;
   assign pll_fail_o = RETRY_LIMIT_EN && (MAX_RETRY > 0);
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_rst_seq
//
// Self-checking bench for pll_rst_seq with small timing parameters. A
// phase/elapsed-time reference model tracks what the supervisor should be
// doing; directed scenarios also check key latencies against closed-form
// expectations. Works with or without PLL_RST_SEQ_RETRY_LIMIT_EN defined.
// -----------------------------------------------------------------------------
module tb_pll_rst_seq;

   localparam int HOLD = 4;
   localparam int TO   = 20;
   localparam int STAB = 8;
   localparam int MAXR = 2;

   localparam int P_HOLD = 0;
   localparam int P_WAIT = 1;
   localparam int P_STAB = 2;
   localparam int P_RUN  = 3;
   localparam int P_FAIL = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lock = 1'b0;
   logic       pll_reset, sys_rst, ready, pll_fail;
   logic [7:0] relock_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: which phase the sequence is in, how many edges it
   // has spent there, retry/relock tallies and the two-edge lock delay line.
   int m_phase, m_el, m_retries, m_relocks;
   bit m_s1, m_s2;

   pll_rst_seq #(
      .RST_HOLD_CYC    (HOLD),
      .LOCK_TIMEOUT_CYC(TO),
      .LOCK_STABLE_CYC (STAB),
      .MAX_RETRY       (MAXR)
   ) dut (
      .clkin_i     (clk),
      .reset_i     (rst),
      .pll_lock_i  (lock),
      .pll_reset_o (pll_reset),
      .sys_rst_o   (sys_rst),
      .ready_o     (ready),
      .relock_cnt_o(relock_cnt),
      .pll_fail_o  (pll_fail)
   );

   always #10 clk = ~clk;

   wire [11:0] dut_vec = {pll_reset, sys_rst, ready, pll_fail, relock_cnt};

   function automatic void model_reset();
      m_phase   = P_HOLD;
      m_el      = 0;
      m_retries = 0;
      m_relocks = 0;
      m_s1      = 1'b0;
      m_s2      = 1'b0;
   endfunction

   function automatic void model_edge(input bit lk);
      bit seen;
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = lk;
      case (m_phase)
         P_HOLD: begin
            m_el++;
            if (m_el == HOLD) begin m_phase = P_WAIT; m_el = 0; end
         end
         P_WAIT: begin
            if (seen) begin
               m_phase = P_STAB; m_el = 0;
            end else begin
               m_el++;
               if (m_el == TO) begin
                  m_el = 0;
                  m_retries++;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
                  m_phase = (m_retries >= MAXR) ? P_FAIL : P_HOLD;
`else
                  m_phase = P_HOLD;
`endif
               end
            end
         end
         P_STAB: begin
            if (!seen) begin
               m_phase = P_WAIT; m_el = 0;
            end else begin
               m_el++;
               if (m_el == STAB) begin m_phase = P_RUN; m_el = 0; end
            end
         end
         P_RUN: begin
            m_retries = 0;
            if (!seen) begin
               m_phase = P_HOLD;
               m_el = 0;
               if (m_relocks < 255) m_relocks++;
            end
         end
         default: ;
      endcase
   endfunction

   function automatic logic [11:0] exp_vec();
      return {(m_phase == P_HOLD) || (m_phase == P_FAIL), m_phase != P_RUN,
              m_phase == P_RUN, m_phase == P_FAIL, 8'(m_relocks)};
   endfunction

   // One clock cycle with pll_lock held at lk across the sampling edge.
   task automatic step(input bit lk);
      lock = lk;
      @(posedge clk);
      model_edge(lk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      lock = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      lock = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      n_tests++; if (pll_reset !== 1'b1) begin n_fail++; $display("FAIL reset_pll_reset: got %b want 1", pll_reset); end
      n_tests++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL reset_sys_rst: got %b want 1", sys_rst); end
      n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
      n_tests++; if (relock_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_relock: got %0d want 0", relock_cnt); end
      n_tests++; if (pll_fail !== 1'b0) begin n_fail++; $display("FAIL reset_pll_fail: got %b want 0", pll_fail); end
      rst = 1'b0;
   endtask

   task automatic test_hold_release();
      int fall;
      do_reset();
      fall = 0;
      for (int i = 1; i <= 10; i++) begin
         step(1'b0);
         n_tests++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL hold_vec edge %0d: got %h want %h", i, dut_vec, exp_vec()); end
         if (fall == 0 && pll_reset === 1'b0) fall = i;
      end
      n_tests++;
      if (fall != HOLD) begin n_fail++; $display("FAIL hold_len: got %0d want %0d", fall, HOLD); end
   endtask

   task automatic test_lock_latency();
      int n;
      do_reset();
      for (int i = 0; i < 20 && pll_reset !== 1'b0; i++) step(1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0);
         n_tests++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL prelock_vec: got %h want %h", dut_vec, exp_vec()); end
      end
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         step(1'b1);
         n_tests++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL lock_vec edge %0d: got %h want %h", i, dut_vec, exp_vec()); end
         if (ready === 1'b1) begin n = i; break; end
      end
      // Two synchronizer edges, one edge to enter STAB, then STAB counting edges.
      n_tests++;
      if (n != STAB + 3) begin n_fail++; $display("FAIL ready_latency: got %0d want %0d", n, STAB + 3); end
      n_tests++;
      if (sys_rst !== 1'b0 || relock_cnt !== 8'd0) begin
         n_fail++; $display("FAIL run_outputs: got sys_rst=%b relock=%0d want 0/0", sys_rst, relock_cnt);
      end
   endtask

   task automatic test_relock();
      int k, n;
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         step(1'b0);
         n_tests++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL drop_vec edge %0d: got %h want %h", i, dut_vec, exp_vec()); end
         if (sys_rst === 1'b1) begin k = i; break; end
      end
      n_tests++;
      if (k != 3) begin n_fail++; $display("FAIL drop_latency: got %0d want 3", k); end
      n_tests++;
      if (pll_reset !== 1'b1 || relock_cnt !== 8'd1) begin
         n_fail++; $display("FAIL drop_outputs: got pll_reset=%b relock=%0d want 1/1", pll_reset, relock_cnt);
      end
      n = 0;
      for (int i = 1; i <= 60; i++) begin
         step(1'b1);
         n_tests++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL relock_vec edge %0d: got %h want %h", i, dut_vec, exp_vec()); end
         if (ready === 1'b1) begin n = i; break; end
      end
      // The synchronizer is already full when the hold ends, so one WAIT edge
      // suffices before the STAB count.
      n_tests++;
      if (n != HOLD + 1 + STAB) begin n_fail++; $display("FAIL relock_latency: got %0d want %0d", n, HOLD + 1 + STAB); end
   endtask

   task automatic test_stab_glitch();
      int n;
      do_reset();
      for (int i = 0; i < 20 && pll_reset !== 1'b0; i++) step(1'b0);
      // Three edges to reach STAB with count 0, five more bring it to 5.
      repeat (8) step(1'b1);
      step(1'b0);
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL glitch_low_vec: got %h want %h", dut_vec, exp_vec()); end
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         step(1'b1);
         n_tests++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL glitch_vec edge %0d: got %h want %h", i, dut_vec, exp_vec()); end
         if (ready === 1'b1) begin n = i; break; end
      end
      // The low sample reaches the FSM on the second edge, STAB is re-entered
      // on the third, then a full fresh STAB count follows.
      n_tests++;
      if (n != 3 + STAB) begin n_fail++; $display("FAIL glitch_latency: got %0d want %0d", n, 3 + STAB); end
   endtask

   task automatic test_subcycle_glitch();
      for (int i = 0; i < 10; i++) begin
         lock = 1'b1;
         #5 lock = 1'b0;
         #5 lock = 1'b1;
         @(posedge clk);
         model_edge(1'b1);
         #1;
         n_tests++;
         if (ready !== 1'b1) begin n_fail++; $display("FAIL subcycle_glitch %0d: got ready=%b want 1", i, ready); end
      end
   endtask

   task automatic test_timeout();
      int rises[$];
      int fail_edge;
      logic prev;
      do_reset();
      prev = pll_reset;
      fail_edge = 0;
      for (int i = 1; i <= 80; i++) begin
         step(1'b0);
         n_tests++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL timeout_vec edge %0d: got %h want %h", i, dut_vec, exp_vec()); end
         if (prev === 1'b0 && pll_reset === 1'b1) rises.push_back(i);
         if (fail_edge == 0 && pll_fail === 1'b1) fail_edge = i;
         prev = pll_reset;
      end
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
      n_tests++;
      if (fail_edge != MAXR * (HOLD + TO)) begin n_fail++; $display("FAIL fail_edge: got %0d want %0d", fail_edge, MAXR * (HOLD + TO)); end
      n_tests++;
      if (pll_reset !== 1'b1 || pll_fail !== 1'b1) begin
         n_fail++; $display("FAIL fail_stuck: got pll_reset=%b pll_fail=%b want 1/1", pll_reset, pll_fail);
      end
`else
      n_tests++;
      if (rises.size() != 3) begin n_fail++; $display("FAIL retry_count: got %0d want 3", rises.size()); end
      for (int i = 0; i < rises.size(); i++) begin
         n_tests++;
         if (rises[i] != (i + 1) * (HOLD + TO)) begin
            n_fail++; $display("FAIL retry_edge %0d: got %0d want %0d", i, rises[i], (i + 1) * (HOLD + TO));
         end
      end
      n_tests++;
      if (pll_fail !== 1'b0) begin n_fail++; $display("FAIL no_fail_flag: got %b want 0", pll_fail); end
`endif
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 40 && ready !== 1'b1; i++) step(1'b1);
      repeat (3) step(1'b0);
      repeat (9) step(1'b1);
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL pre_async_vec: got %h want %h", dut_vec, exp_vec()); end
      #3 rst = 1'b1;
      #1;
      n_tests++;
      if ({pll_reset, sys_rst, ready} !== 3'b110) begin
         n_fail++; $display("FAIL async_outputs: got %b want 110", {pll_reset, sys_rst, ready});
      end
      n_tests++;
      if (relock_cnt !== 8'd0) begin n_fail++; $display("FAIL async_relock: got %0d want 0", relock_cnt); end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_relock_saturation();
      int want;
      bit reached;
      do_reset();
      for (int it = 0; it < 258; it++) begin
         reached = 1'b0;
         for (int i = 0; i < 40; i++) begin
            step(1'b1);
            if (ready === 1'b1) begin reached = 1'b1; break; end
         end
         if (!reached) begin
            n_tests++; n_fail++;
            $display("FAIL sat_ready_timeout iter %0d: got ready=%b want 1", it, ready);
            break;
         end
         repeat (3) step(1'b0);
         want = (it + 1 > 255) ? 255 : it + 1;
         n_tests++;
         if (relock_cnt !== 8'(want)) begin n_fail++; $display("FAIL sat_relock iter %0d: got %0d want %0d", it, relock_cnt, want); end
      end
   endtask

   task automatic test_random();
      int len;
      bit lvl;
      do_reset();
      for (int seg = 0; seg < 160; seg++) begin
         if (seg % 50 == 49) do_reset();
         lvl = ($urandom_range(0, 3) != 0);
         if (lvl) len = $urandom_range(1, 30);
         else if ($urandom_range(0, 7) == 0) len = $urandom_range(20, 50);
         else len = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) begin
            step(lvl);
            n_tests++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random_vec seg %0d: got %h want %h", seg, dut_vec, exp_vec()); end
         end
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #5;
      test_reset();
      test_hold_release();
      test_lock_latency();
      test_relock();
      test_subcycle_glitch();
      test_stab_glitch();
      test_timeout();
      test_async_reset();
      test_relock_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
